// File: rtl/mmio_bridge.sv
// Memory-mapped I/O bridge: decodes the region tag of a CPU access, runs a
// req/ack handshake with one slave, bounds it with a timeout and logs faults.
module mmio_bridge #(
    parameter int NSLV    = 8,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SEL_LO  = 20,
    parameter logic [NSLV*(AW-SEL_LO)-1:0] TAGS = '0,
    parameter int TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               m_req,
    input  logic               m_we,
    input  logic [AW-1:0]      m_addr,
    input  logic [DW-1:0]      m_wdata,
    input  logic [DW/8-1:0]    m_wstrb,
    output logic               m_ready,
    output logic [DW-1:0]      m_rdata,
    output logic               m_err,
    output logic [NSLV-1:0]    s_req,
    output logic               s_we,
    output logic [AW-1:0]      s_addr,
    output logic [DW-1:0]      s_wdata,
    output logic [DW/8-1:0]    s_wstrb,
    input  logic [NSLV-1:0]    s_ack,
    input  logic [NSLV*DW-1:0] s_rdata,
    input  logic               err_clr,
    output logic [1:0]         err_code,
    output logic [AW-1:0]      err_addr,
    output logic [15:0]        err_count
);
    localparam int TW = AW - SEL_LO;
    localparam int SW = DW / 8;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state_q, state_d;
    logic [NSLV-1:0] s_req_q, s_req_d;
    logic            s_we_q, s_we_d;
    logic [AW-1:0]   s_addr_q, s_addr_d;
    logic [DW-1:0]   s_wdata_q, s_wdata_d;
    logic [SW-1:0]   s_wstrb_q, s_wstrb_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic            m_ready_q, m_ready_d;
    logic            m_err_q, m_err_d;
    logic [DW-1:0]   m_rdata_q, m_rdata_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [AW-1:0]   err_addr_q, err_addr_d;
    logic [15:0]     err_count_q, err_count_d;

    logic            hit;
    logic [NSLV-1:0] hit_vec;
    logic [DW-1:0]   sel_rdata;
    logic            acked;
    logic            fault;
    logic [1:0]      fault_code;
    logic [AW-1:0]   fault_addr;
    logic [1:0]      code_base;
    logic [AW-1:0]   addr_base;
    logic [15:0]     count_base;

    // Lowest-index matching tag wins when several slots share a tag
    always_comb begin
        hit     = 1'b0;
        hit_vec = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (!hit && m_addr[AW-1:SEL_LO] == TAGS[i*TW +: TW]) begin
                hit        = 1'b1;
                hit_vec[i] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (s_req_q[i]) sel_rdata = s_rdata[i*DW +: DW];
        end
    end

    assign acked   = |(s_ack & s_req_q);
    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d    = state_q;
        s_req_d    = s_req_q;
        s_we_d     = s_we_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        s_wstrb_d  = s_wstrb_q;
        cnt_d      = cnt_q;
        m_ready_d  = 1'b0;
        m_err_d    = m_err_q;
        m_rdata_d  = m_rdata_q;
        fault      = 1'b0;
        fault_code = 2'd0;
        fault_addr = s_addr_q;
        case (state_q)
            IDLE: begin
                if (m_req) begin
                    s_we_d    = m_we;
                    s_addr_d  = m_addr;
                    s_wdata_d = m_wdata;
                    s_wstrb_d = m_wstrb;
                    if (hit) begin
                        s_req_d = hit_vec;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end else begin
                        m_ready_d  = 1'b1;
                        m_err_d    = 1'b1;
                        m_rdata_d  = '0;
                        fault      = 1'b1;
                        fault_code = m_we ? 2'd2 : 2'd1;
                        fault_addr = m_addr;
                        state_d    = RESP;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_inc;
                // An ack arriving on the final allowed cycle still completes normally
                if (acked) begin
                    s_req_d   = '0;
                    m_ready_d = 1'b1;
                    m_err_d   = 1'b0;
                    m_rdata_d = s_we_q ? '0 : sel_rdata;
                    state_d   = RESP;
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    s_req_d    = '0;
                    m_ready_d  = 1'b1;
                    m_err_d    = 1'b1;
                    m_rdata_d  = '0;
                    fault      = 1'b1;
                    fault_code = 2'd3;
                    state_d    = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A clear in the same cycle as a new fault leaves only the new fault logged
    always_comb begin
        code_base   = err_clr ? 2'd0  : err_code_q;
        addr_base   = err_clr ? '0    : err_addr_q;
        count_base  = err_clr ? 16'd0 : err_count_q;
        err_code_d  = code_base;
        err_addr_d  = addr_base;
        err_count_d = count_base;
        if (fault) begin
            if (code_base == 2'd0) begin
                err_code_d = fault_code;
                err_addr_d = fault_addr;
            end
            if (count_base != 16'hFFFF) err_count_d = count_base + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            s_req_q     <= '0;
            s_we_q      <= 1'b0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            s_wstrb_q   <= '0;
            cnt_q       <= '0;
            m_ready_q   <= 1'b0;
            m_err_q     <= 1'b0;
            m_rdata_q   <= '0;
            err_code_q  <= 2'd0;
            err_addr_q  <= '0;
            err_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            s_req_q     <= s_req_d;
            s_we_q      <= s_we_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            s_wstrb_q   <= s_wstrb_d;
            cnt_q       <= cnt_d;
            m_ready_q   <= m_ready_d;
            m_err_q     <= m_err_d;
            m_rdata_q   <= m_rdata_d;
            err_code_q  <= err_code_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign m_ready   = m_ready_q;
    assign m_err     = m_err_q;
    assign m_rdata   = m_rdata_q;
    assign s_req     = s_req_q;
    assign s_we      = s_we_q;
    assign s_addr    = s_addr_q;
    assign s_wdata   = s_wdata_q;
    assign s_wstrb   = s_wstrb_q;
    assign err_code  = err_code_q;
    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;
endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: expected responses are queued when an
// access is issued and compared by a monitor whenever m_ready is seen.
module tb_mmio_bridge;
    localparam int NSLV    = 8;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int SEL_LO  = 20;
    localparam int TIMEOUT = 4;
    // slot order 7..0: 007, 006, 010, 005, 004, 002, 010, 001
    localparam logic [NSLV*12-1:0] TAGS =
        {12'h007, 12'h006, 12'h010, 12'h005, 12'h004, 12'h002, 12'h010, 12'h001};

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              m_req, m_we;
    logic [AW-1:0]     m_addr;
    logic [DW-1:0]     m_wdata;
    logic [DW/8-1:0]   m_wstrb;
    logic              m_ready, m_err;
    logic [DW-1:0]     m_rdata;
    logic [NSLV-1:0]   s_req;
    logic              s_we;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic [DW/8-1:0]   s_wstrb;
    logic [NSLV-1:0]   s_ack;
    logic [NSLV*DW-1:0] s_rdata;
    logic              err_clr;
    logic [1:0]        err_code;
    logic [AW-1:0]     err_addr;
    logic [15:0]       err_count;

    int    errors = 0;
    int    checks = 0;
    resp_t exp_q[$];
    resp_t exp_r;

    mmio_bridge #(
        .NSLV(NSLV), .AW(AW), .DW(DW), .SEL_LO(SEL_LO), .TAGS(TAGS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ack(s_ack), .s_rdata(s_rdata),
        .err_clr(err_clr), .err_code(err_code), .err_addr(err_addr), .err_count(err_count)
    );

    always #5 clock = ~clock;

    // Scoreboard consumer: every response pulse must match the oldest queued expectation
    always @(negedge clock) begin
        if (reset_n && m_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_resp: m_ready=1 rdata=%h err=%b, none expected", m_rdata, m_err);
            end else begin
                exp_r = exp_q.pop_front();
                if (m_rdata !== exp_r.rdata || m_err !== exp_r.err) begin
                    errors++;
                    $display("[TB] FAIL resp_data: got rdata=%h err=%b, expected rdata=%h err=%b",
                             m_rdata, m_err, exp_r.rdata, exp_r.err);
                end
            end
        end
    end

    function automatic resp_t mk(input logic [31:0] rdata, input logic err);
        resp_t r;
        r.rdata = rdata;
        r.err   = err;
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb);
        m_req   = 1'b1;
        m_we    = we;
        m_addr  = addr;
        m_wdata = wdata;
        m_wstrb = wstrb;
    endtask

    task automatic idle_master();
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
    endtask

    task automatic clear_log();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #11;
        checks++;
        if (m_ready !== 1'b0 || m_err !== 1'b0 || m_rdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_m: ready=%b err=%b rdata=%h, expected 0 0 0", m_ready, m_err, m_rdata);
        end
        checks++;
        if (s_req !== '0 || s_we !== 1'b0 || s_addr !== '0 || s_wdata !== '0 || s_wstrb !== '0) begin
            errors++;
            $display("[TB] FAIL reset_s: s_req=%b s_addr=%h, expected all zero", s_req, s_addr);
        end
        checks++;
        if (err_code !== 2'd0 || err_addr !== '0 || err_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_log: code=%0d addr=%h count=%0d, expected 0", err_code, err_addr, err_count);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (m_ready !== 1'b0 || s_req !== '0) begin
            errors++;
            $display("[TB] FAIL reset_idle: ready=%b s_req=%b, expected 0", m_ready, s_req);
        end
    endtask

    task automatic test_read_hit();
        s_rdata[3*32 +: 32] = 32'hDEAD_BEEF;
        issue(1'b0, 32'h0040_0010, 32'h0, 4'hF);
        exp_q.push_back(mk(32'hDEAD_BEEF, 1'b0));
        tick();
        checks++;
        if (s_req !== 8'b0000_1000 || s_addr !== 32'h0040_0010 || s_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hit_sreq: s_req=%b s_addr=%h s_we=%b, expected 00001000 00400010 0", s_req, s_addr, s_we);
        end
        s_ack = 8'b0000_1000;
        tick();
        checks++;
        if (m_ready !== 1'b1 || s_req !== '0) begin
            errors++;
            $display("[TB] FAIL hit_ready: m_ready=%b s_req=%b in cycle 2, expected 1 and 0", m_ready, s_req);
        end
        idle_master();
        s_ack = '0;
        tick();
        checks++;
        if (m_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hit_pulse: m_ready=%b in cycle 3, expected 0", m_ready);
        end
    endtask

    task automatic test_write_miss();
        issue(1'b1, 32'hFFF0_0000, 32'h1234_5678, 4'hF);
        exp_q.push_back(mk(32'h0, 1'b1));
        tick();
        checks++;
        if (m_ready !== 1'b1 || s_req !== '0) begin
            errors++;
            $display("[TB] FAIL miss_ready: m_ready=%b s_req=%b in cycle 1, expected 1 and 0", m_ready, s_req);
        end
        checks++;
        if (err_code !== 2'd2 || err_addr !== 32'hFFF0_0000 || err_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL miss_log: code=%0d addr=%h count=%0d, expected 2 fff00000 1", err_code, err_addr, err_count);
        end
        idle_master();
        tick();
        clear_log();
        checks++;
        if (err_code !== 2'd0 || err_addr !== '0 || err_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL miss_clear: code=%0d addr=%h count=%0d, expected 0", err_code, err_addr, err_count);
        end
    endtask

    task automatic test_write_hit();
        issue(1'b1, 32'h0100_0004, 32'hCAFE_F00D, 4'b0101);
        exp_q.push_back(mk(32'h0, 1'b0));
        tick();
        checks++;
        if (s_req !== 8'b0000_0010 || s_we !== 1'b1 || s_wdata !== 32'hCAFE_F00D || s_wstrb !== 4'b0101) begin
            errors++;
            $display("[TB] FAIL wr_fields: s_req=%b we=%b wdata=%h wstrb=%b, expected 00000010 1 cafef00d 0101",
                     s_req, s_we, s_wdata, s_wstrb);
        end
        tick();
        checks++;
        if (m_ready !== 1'b0 || s_req !== 8'b0000_0010) begin
            errors++;
            $display("[TB] FAIL wr_wait: m_ready=%b s_req=%b, expected 0 00000010", m_ready, s_req);
        end
        s_ack = 8'b0000_0010;
        tick();
        checks++;
        if (m_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wr_ready: m_ready=%b in cycle 3, expected 1", m_ready);
        end
        idle_master();
        s_ack = '0;
        tick();
    endtask

    task automatic test_timeout();
        int high = 0;
        int cyc;
        issue(1'b0, 32'h0040_0020, 32'h0, 4'hF);
        exp_q.push_back(mk(32'h0, 1'b1));
        tick();
        cyc = 1;
        while (m_ready !== 1'b1 && cyc < 20) begin
            if (s_req === 8'b0000_1000) high++;
            tick();
            cyc++;
        end
        checks++;
        if (cyc != TIMEOUT + 1 || high != TIMEOUT) begin
            errors++;
            $display("[TB] FAIL timeout_cycles: m_ready at cycle %0d with s_req high %0d cycles, expected 5 and 4", cyc, high);
        end
        checks++;
        if (err_code !== 2'd3 || err_addr !== 32'h0040_0020 || err_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL timeout_log: code=%0d addr=%h count=%0d, expected 3 00400020 1", err_code, err_addr, err_count);
        end
        idle_master();
        tick();
        clear_log();
    endtask

    task automatic test_ack_at_timeout();
        issue(1'b0, 32'h0040_0030, 32'h0, 4'hF);
        exp_q.push_back(mk(32'hDEAD_BEEF, 1'b0));
        repeat (4) tick();
        s_ack = 8'b0000_1000;
        tick();
        checks++;
        if (m_ready !== 1'b1 || err_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL ack_wins: m_ready=%b err_count=%0d in cycle 5, expected 1 0", m_ready, err_count);
        end
        idle_master();
        s_ack = '0;
        tick();
    endtask

    task automatic test_err_log();
        int cyc = 0;
        issue(1'b0, 32'hF000_1234, 32'h0, 4'hF);
        exp_q.push_back(mk(32'h0, 1'b1));
        tick();
        idle_master();
        tick();
        issue(1'b1, 32'h0020_0008, 32'h0000_0055, 4'h1);
        exp_q.push_back(mk(32'h0, 1'b1));
        tick();
        while (m_ready !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++;
        if (err_code !== 2'd1 || err_addr !== 32'hF000_1234 || err_count !== 16'd2) begin
            errors++;
            $display("[TB] FAIL log_sticky: code=%0d addr=%h count=%0d, expected 1 f0001234 2", err_code, err_addr, err_count);
        end
        idle_master();
        tick();
        issue(1'b1, 32'hFFF0_0040, 32'h0, 4'hF);
        err_clr = 1'b1;
        exp_q.push_back(mk(32'h0, 1'b1));
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_code !== 2'd2 || err_addr !== 32'hFFF0_0040 || err_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL log_clr_fault: code=%0d addr=%h count=%0d, expected 2 fff00040 1", err_code, err_addr, err_count);
        end
        idle_master();
        tick();
        clear_log();
        checks++;
        if (err_code !== 2'd0 || err_addr !== '0 || err_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL log_clear: code=%0d addr=%h count=%0d, expected 0", err_code, err_addr, err_count);
        end
    endtask

    task automatic test_dup_tags();
        issue(1'b0, 32'h0100_0000, 32'h0, 4'hF);
        exp_q.push_back(mk(32'hC0DE_0001, 1'b0));
        tick();
        checks++;
        if (s_req !== 8'b0000_0010) begin
            errors++;
            $display("[TB] FAIL dup_sel: s_req=%b, expected 00000010", s_req);
        end
        s_ack = 8'b0010_0000;
        tick();
        checks++;
        if (m_ready !== 1'b0 || s_req !== 8'b0000_0010) begin
            errors++;
            $display("[TB] FAIL dup_stray: m_ready=%b s_req=%b after stray ack, expected 0 00000010", m_ready, s_req);
        end
        s_ack = 8'b0000_0010;
        tick();
        checks++;
        if (m_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL dup_ready: m_ready=%b, expected 1", m_ready);
        end
        idle_master();
        s_ack = '0;
        tick();
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 32'h0040_0000, 32'h0, 4'hF);
        exp_q.push_back(mk(32'hDEAD_BEEF, 1'b0));
        tick();
        s_ack = 8'b0000_1000;
        tick();
        checks++;
        if (m_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_first: m_ready=%b in cycle 2, expected 1", m_ready);
        end
        s_ack  = '0;
        m_addr = 32'h0020_0004;
        exp_q.push_back(mk(32'hC0DE_0002, 1'b0));
        tick();
        checks++;
        if (m_ready !== 1'b0 || s_req !== '0) begin
            errors++;
            $display("[TB] FAIL b2b_idle: m_ready=%b s_req=%b in cycle 3, expected 0 0", m_ready, s_req);
        end
        tick();
        checks++;
        if (s_req !== 8'b0000_0100) begin
            errors++;
            $display("[TB] FAIL b2b_sreq: s_req=%b in cycle 4, expected 00000100", s_req);
        end
        s_ack = 8'b0000_0100;
        tick();
        checks++;
        if (m_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_second: m_ready=%b in cycle 5, expected 1", m_ready);
        end
        idle_master();
        s_ack = '0;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        int seen = 0;
        issue(1'b0, 32'h0040_0000, 32'h0, 4'hF);
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (s_req !== '0 || m_ready !== 1'b0 || s_addr !== '0 || err_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL rst_busy: s_req=%b m_ready=%b s_addr=%h count=%0d, expected all 0",
                     s_req, m_ready, s_addr, err_count);
        end
        idle_master();
        #2 reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (m_ready === 1'b1 || s_req !== '0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("[TB] FAIL rst_no_resp: activity in %0d cycles after reset, expected 0", seen);
        end
    endtask

    initial begin
        reset_n = 1'b1;
        err_clr = 1'b0;
        s_ack   = '0;
        for (int i = 0; i < NSLV; i++) s_rdata[i*32 +: 32] = 32'hC0DE_0000 + i;
        idle_master();
        test_reset();
        test_read_hit();
        test_write_miss();
        test_write_hit();
        test_timeout();
        test_ack_at_timeout();
        test_err_log();
        test_dup_tags();
        test_back_to_back();
        test_reset_mid_busy();
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mmio_bridge.md
# mmio_bridge

Parametrised memory-mapped I/O bridge between the CPU data port and up to `NSLV` peripheral slaves (data memory, VGA, keyboard, LED, HEX, timers, switches). It decodes the region tag in the upper address bits, runs a req/ack handshake with the selected slave, and bounds every access with a timeout. It returns registered read data and logs bus faults (unmapped address, slave timeout) in sticky error registers. It replaces the flat combinational read mux and the ad-hoc write `case` at top level.

## Interface

- `NSLV`, 8, number of slave channels (1..16)
- `AW`, 32, address width
- `DW`, 32, data width (multiple of 8)
- `SEL_LO`, 20, LSB of the region tag; tag is `addr[AW-1:SEL_LO]`
- `TAGS`, all zero, packed `NSLV` x `(AW-SEL_LO)` bits; slave i's tag is at slice i
- `TIMEOUT`, 255, max BUSY cycles before abort (>=1)

Ports:

- `clock`  in  1  system clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `m_req`  in  1  master request, held until `m_ready`
- `m_we`  in  1  1 = write, 0 = read
- `m_addr`  in  AW  access address
- `m_wdata`  in  DW  write data
- `m_wstrb`  in  DW/8  byte enables
- `m_ready`  out  1  one-cycle completion pulse
- `m_rdata`  out  DW  read data, valid while `m_ready`
- `m_err`  out  1  access faulted, valid while `m_ready`
- `s_req`  out  NSLV  one-hot slave request
- `s_we`, `s_addr`, `s_wdata`, `s_wstrb`  out  1/AW/DW/DW/8  latched access fields, shared by all slaves
- `s_ack`  in  NSLV  per-slave completion
- `s_rdata`  in  NSLV*DW  per-slave read data, slice i = slave i
- `err_clr`  in  1  clears the error registers
- `err_code`  out  2  first error: 0 none, 1 invalid read, 2 invalid write, 3 timeout
- `err_addr`  out  AW  address of the first error
- `err_count`  out  16  number of errors, saturating

## Operation

- FSM states are IDLE, BUSY and RESP. Reset state is IDLE.
- IDLE:
  - On `m_req`, latch `we/addr/wdata/wstrb` and compare the tag against all `TAGS`.
  - If more than one tag matches, the lowest index wins.
  - On a hit, drive `s_req[i]`=1 and go to BUSY.
  - On a miss, set err = 1 (read) or 2 (write), set rdata = 0 and go to RESP. No `s_req` is raised.
- BUSY:
  - Hold `s_req[i]` and the `s_*` fields stable. The timeout counter increments each cycle.
  - When `s_ack[i]`=1: capture `s_rdata[i]` (reads only; writes capture 0), clear `s_req`, go to RESP with err = 0.
  - Acks from non-selected slaves are ignored.
  - When the counter reaches `TIMEOUT` with no ack: clear `s_req`, set err = 3, rdata = 0, go to RESP. If ack and timeout occur in the same cycle, the ack wins.
- RESP:
  - Assert `m_ready` with registered `m_rdata`/`m_err` for exactly one cycle, then go to IDLE.
  - `m_req` is sampled again only in IDLE, so it is ignored in BUSY and RESP.
- Error log, updated on the RESP entry of a faulting access:
  - `err_code`/`err_addr` are written only if `err_code`==0, so the first error is sticky.
  - `err_count` increments and saturates at 16'hFFFF.
  - `err_clr` zeroes all three. If `err_clr` coincides with a new error, the new error is recorded and `err_count`=1.
- Timeout counter width is `$clog2(TIMEOUT+1)`. It is cleared on every IDLE->BUSY transition.

## Timing

- Reset (async assert, sync release): state=IDLE; `m_ready`=0, `m_err`=0, `m_rdata`=0, `s_req`=0, all `s_*` fields 0, `err_code`=0, `err_addr`=0, `err_count`=0, timeout counter 0.
- Reset in BUSY aborts the access immediately: `s_req` drops with no response and no error logged.
- Cycle numbering for a hit with zero wait states: `m_req` seen in IDLE at cycle 0; `s_req` high in cycle 1; `s_ack` seen in cycle 1; `m_ready` high in cycle 2. Each extra wait state adds one cycle.
- Miss: `m_ready` is high in cycle 1.
- Timeout: `s_req` is high in cycles 1..`TIMEOUT`, and `m_ready`/`m_err` are high in cycle `TIMEOUT`+1.
- Back-to-back: `m_req` held high after `m_ready` is accepted in the following IDLE cycle. Minimum throughput is one access per 3 cycles.
- All outputs are registered; there is no combinational path from `m_*` or `s_*` inputs to outputs.

## Test plan

- Read hit, `TAGS` slot 3 = 12'h004, `m_addr`=32'h0040_0010, slave 3 acks in its first request cycle with 32'hDEAD_BEEF -> `s_req`=8'b0000_1000 in cycle 1; `m_ready`=1, `m_rdata`=32'hDEAD_BEEF, `m_err`=0 in cycle 2.
- Write miss to 32'hFFF0_0000 -> no `s_req`; `m_ready`=1, `m_err`=1 in cycle 1; `err_code`=2, `err_addr`=32'hFFF0_0000, `err_count`=1.
- `TIMEOUT`=4, slave never acks -> `s_req` high for 4 cycles, `m_err`=1 in cycle 5, `err_code`=3. An ack in cycle 4 instead gives `m_err`=0.
- Two faults then `err_clr`: first an invalid read at A, then a timeout at B -> `err_code`=1, `err_addr`=A, `err_count`=2; after `err_clr` all are 0. With `err_clr` and a new fault in the same cycle -> `err_count`=1.
- Duplicate tags in slots 1 and 5 -> only `s_req[1]`; a stray `s_ack[5]` during BUSY is ignored.
- `reset_n` pulsed low mid-BUSY -> `s_req`=0 and all outputs at reset values asynchronously; no `m_ready` afterward until a new `m_req`.
